// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester arithmetic-unit arbiter (alu_arb2).
// Holds the op encodings, the sequencer state type and the default widths.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 3;

  // Op encoding is {sel[1:0], carryin}, matching the arithmetic unit.
  localparam logic [2:0] OP_PASS  = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_ADDC  = 3'b011;
  localparam logic [2:0] OP_ADDNB = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_PASS2 = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arb2_rr.sv
// Combinational two-way round-robin winner select for alu_arb2.
// With ALU_ARB_LOCK_EN defined, an active lock pins the grant to the
// requester that won last, ignoring the other one.
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
`ifdef ALU_ARB_LOCK_EN
  input  logic lock_active,
`endif
  output logic grant_valid,
  output logic grant
);

  // Pick the winner: a lone requester wins, a tie goes to the one that did not win last.
  always_comb begin
    grant_valid = valid0 | valid1;
    grant       = 1'b0;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else if (valid1) begin
      grant = 1'b1;
    end
`ifdef ALU_ARB_LOCK_EN
    if (lock_active) begin
      grant       = last_grant;
      grant_valid = last_grant ? valid1 : valid0;
    end
`endif
  end

endmodule

// File: rtl/alu_arb2.sv
// alu_arb2: round-robin arbiter and sequencer in front of the shared 8-bit
// arithmetic unit. Accepts one command at a time from two requesters, drives
// the unit from registered operands, captures its result and returns it to
// the requester that issued the command.
// Optional feature: define ALU_ARB_LOCK_EN to add req0_lock/req1_lock, which
// let a requester keep the grant across consecutive commands.
module alu_arb2
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
`ifdef ALU_ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic [1:0]        alu_sel,
  output logic              alu_carryin,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              last_grant
);

  state_t            state;
  logic [OP_W-1:0]   op_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] result_r;
  logic              grant_valid;
  logic              grant;
  logic              accept;
  logic              rsp_done;
`ifdef ALU_ARB_LOCK_EN
  logic              lock_active;
`endif

  rr_arb2 u_rr (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
`ifdef ALU_ARB_LOCK_EN
    .lock_active (lock_active),
`endif
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // The current owner is always last_grant, so it steers the response side too.
  assign accept     = (state == IDLE) && grant_valid;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign rsp0_valid = (state == RESP) && !last_grant;
  assign rsp1_valid = (state == RESP) && last_grant;
  assign rsp0_data  = rsp0_valid ? result_r : '0;
  assign rsp1_data  = rsp1_valid ? result_r : '0;
  assign rsp_done   = (state == RESP) && (last_grant ? rsp1_ready : rsp0_ready);
  assign busy       = (state != IDLE);
  assign alu_sel    = op_r[2:1];
  assign alu_carryin = op_r[0];
  assign alu_a      = a_r;
  assign alu_b      = b_r;

  // Sequencer: latch the winning command, hold it for one EXEC cycle, then wait for the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      result_r    <= '0;
      last_grant  <= 1'b1;
`ifdef ALU_ARB_LOCK_EN
      lock_active <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r       <= grant ? req1_op : req0_op;
            a_r        <= grant ? req1_a : req0_a;
            b_r        <= grant ? req1_b : req0_b;
            last_grant <= grant;
`ifdef ALU_ARB_LOCK_EN
            lock_active <= grant ? req1_lock : req0_lock;
`endif
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_r <= alu_result;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
